// File: rtl/branch_sequencer.sv
// Program counter owner: sequential fetch, taken-branch / CALL / RET redirects, return-address stack.
// Latency: redirect target appears on pc one cycle after it is sampled, with flush high that same cycle.
// Backpressure: stall freezes pc, state, RAS and flags (flush holds); redirect inputs ignored while stalled.
module branch_sequencer #(
    parameter int              PC_W      = 16,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            br_valid,
    input  logic            jump,
    input  logic            is_call,
    input  logic            is_ret,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc,
    output logic            flush,
    output logic            fault,
    output logic            ras_ovf,
    output logic [2:0]      ras_count
);

    localparam int         PTR_W   = $clog2(RAS_DEPTH);
    localparam logic [2:0] DEPTH_C = 3'(RAS_DEPTH);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    logic [1:0]      state;
    logic [PTR_W-1:0] sp;          // next write slot; top of stack is sp-1
    logic [PC_W-1:0] ras_mem [RAS_DEPTH];

    logic active;
    logic do_ret;
    logic do_ret_empty;
    logic do_call;
    logic do_branch;
    logic [PTR_W-1:0] top_idx;

    // Decode the redirect for this cycle with RET > CALL > taken branch priority.
    always_comb begin
        active       = !stall && (state == ST_RUN);
        do_ret       = active && is_ret && (ras_count != 3'd0);
        do_ret_empty = active && is_ret && (ras_count == 3'd0);
        do_call      = active && !is_ret && is_call;
        do_branch    = active && !is_ret && !is_call && br_valid && jump;
        top_idx      = sp - 1'b1;
    end

    // Return-address storage; a push onto a full stack overwrites the oldest slot circularly.
    always_ff @(posedge clk) begin
        if (do_call) begin
            ras_mem[sp] <= pc;
        end
    end

    // PC, sequencing state, stack pointer and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_PC;
            flush     <= 1'b0;
            fault     <= 1'b0;
            ras_ovf   <= 1'b0;
            ras_count <= 3'd0;
            sp        <= '0;
            state     <= ST_RUN;
        end else if (!stall) begin
            case (state)
                ST_RUN: begin
                    if (do_ret) begin
                        pc        <= ras_mem[top_idx];
                        sp        <= top_idx;
                        ras_count <= ras_count - 3'd1;
                        flush     <= 1'b1;
                        state     <= ST_FLUSH;
                    end else if (do_ret_empty) begin
                        fault     <= 1'b1;
                        flush     <= 1'b1;
                        state     <= ST_FAULT;
                    end else if (do_call) begin
                        pc        <= target;
                        sp        <= sp + 1'b1;
                        if (ras_count == DEPTH_C) begin
                            ras_ovf <= 1'b1;
                        end else begin
                            ras_count <= ras_count + 3'd1;
                        end
                        flush     <= 1'b1;
                        state     <= ST_FLUSH;
                    end else if (do_branch) begin
                        pc        <= target;
                        flush     <= 1'b1;
                        state     <= ST_FLUSH;
                    end else begin
                        pc        <= pc + PC_W'(1);
                        flush     <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    // Wrong-path instruction sits in execute: ignore it, take the bubble.
                    pc    <= pc + PC_W'(1);
                    flush <= 1'b0;
                    state <= ST_RUN;
                end
                ST_FAULT: begin
                    flush <= 1'b0;
                end
                default: begin
                    flush <= 1'b0;
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: expected pc/flags queued with each stimulus step, checked after the edge.
// Latency: one cycle per step; every step compares the full observable state.
// Backpressure: stall exercised explicitly in RUN, FLUSH and FAULT.
module tb_branch_sequencer;

    typedef struct packed {
        logic [15:0] pc;
        logic        flush;
        logic        fault;
        logic        ovf;
        logic [2:0]  cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        br_valid = 1'b0;
    logic        jump = 1'b0;
    logic        is_call = 1'b0;
    logic        is_ret = 1'b0;
    logic [15:0] target = 16'h0;
    logic [15:0] pc;
    logic        flush;
    logic        fault;
    logic        ras_ovf;
    logic [2:0]  ras_count;

    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];

    branch_sequencer #(
        .PC_W(16),
        .RESET_PC(16'h0000),
        .RAS_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .br_valid(br_valid),
        .jump(jump),
        .is_call(is_call),
        .is_ret(is_ret),
        .target(target),
        .pc(pc),
        .flush(flush),
        .fault(fault),
        .ras_ovf(ras_ovf),
        .ras_count(ras_count)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, queue the expected post-edge state, then check after the edge.
    task automatic step(input string tag, input logic rs, input logic st, input logic bv,
                        input logic jp, input logic cl, input logic rt, input logic [15:0] tgt,
                        input logic [15:0] e_pc, input logic e_fl, input logic e_ft,
                        input logic e_ov, input logic [2:0] e_cnt);
        exp_t e;
        exp_t got;
        reset    = rs;
        stall    = st;
        br_valid = bv;
        jump     = jp;
        is_call  = cl;
        is_ret   = rt;
        target   = tgt;
        sb_q.push_back('{pc: e_pc, flush: e_fl, fault: e_ft, ovf: e_ov, cnt: e_cnt});
        @(posedge clk);
        #1;
        e   = sb_q.pop_front();
        got = '{pc: pc, flush: flush, fault: fault, ovf: ras_ovf, cnt: ras_count};
        checks++;
        assert (got === e) else begin
            failures++;
            $error("FAIL %s: got pc=%h flush=%b fault=%b ovf=%b cnt=%0d, expected pc=%h flush=%b fault=%b ovf=%b cnt=%0d",
                   tag, got.pc, got.flush, got.fault, got.ovf, got.cnt,
                   e.pc, e.flush, e.fault, e.ovf, e.cnt);
        end
    endtask

    task automatic idle(input string tag, input logic [15:0] e_pc, input logic e_ft,
                        input logic e_ov, input logic [2:0] e_cnt);
        step(tag, 0, 0, 0, 0, 0, 0, 16'h0, e_pc, 1'b0, e_ft, e_ov, e_cnt);
    endtask

    initial begin
        // Reset and sequential fetch
        step("reset0", 1, 0, 0, 0, 0, 0, 16'h0, 16'h0000, 0, 0, 0, 0);
        step("reset1", 1, 0, 1, 1, 1, 0, 16'h1234, 16'h0000, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            idle("seq", 16'(i), 0, 0, 0);
        end

        // Wrap: get to FFFE via a branch, then idle across the boundary
        step("br_fffd", 0, 0, 1, 1, 0, 0, 16'hFFFD, 16'hFFFD, 1, 0, 0, 0);
        idle("bubble_fffe", 16'hFFFE, 0, 0, 0);
        idle("wrap_ffff", 16'hFFFF, 0, 0, 0);
        idle("wrap_0000", 16'h0000, 0, 0, 0);
        idle("wrap_0001", 16'h0001, 0, 0, 0);

        // Taken / not-taken branches, jump without br_valid, branch to self
        step("br_000f", 0, 0, 1, 1, 0, 0, 16'h000F, 16'h000F, 1, 0, 0, 0);
        idle("bubble_0010", 16'h0010, 0, 0, 0);
        step("br_taken", 0, 0, 1, 1, 0, 0, 16'h0040, 16'h0040, 1, 0, 0, 0);
        idle("after_taken", 16'h0041, 0, 0, 0);
        step("br_not_taken", 0, 0, 1, 0, 0, 0, 16'h0099, 16'h0042, 0, 0, 0, 0);
        step("jump_no_valid", 0, 0, 0, 1, 0, 0, 16'h0099, 16'h0043, 0, 0, 0, 0);
        step("br_self", 0, 0, 1, 1, 0, 0, 16'h0043, 16'h0043, 1, 0, 0, 0);
        idle("after_self", 16'h0044, 0, 0, 0);

        // CALL at 0x20, RET from 0x105; redirect inputs during the bubble ignored
        step("br_001f", 0, 0, 1, 1, 0, 0, 16'h001F, 16'h001F, 1, 0, 0, 0);
        idle("bubble_0020", 16'h0020, 0, 0, 0);
        step("call_100", 0, 0, 1, 1, 1, 0, 16'h0100, 16'h0100, 1, 0, 0, 1);
        step("flush_ignores", 0, 0, 1, 1, 1, 1, 16'h0777, 16'h0101, 0, 0, 0, 1);
        for (int i = 2; i <= 5; i++) begin
            idle("in_callee", 16'h0100 + 16'(i), 0, 0, 1);
        end
        step("ret_0020", 0, 0, 0, 0, 0, 1, 16'h0888, 16'h0020, 1, 0, 0, 0);
        idle("after_ret", 16'h0021, 0, 0, 0);

        // Stall holds a pending branch; it is taken on release
        for (int i = 0; i < 3; i++) begin
            step("stall_hold", 0, 1, 1, 1, 0, 0, 16'h0200, 16'h0021, 0, 0, 0, 0);
        end
        step("stall_release", 0, 0, 1, 1, 0, 0, 16'h0200, 16'h0200, 1, 0, 0, 0);
        step("stall_in_flush", 0, 1, 0, 0, 0, 0, 16'h0000, 16'h0200, 1, 0, 0, 0);
        step("reset_in_flush", 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        step("call_then_reset", 0, 0, 0, 0, 1, 0, 16'h0050, 16'h0050, 1, 0, 0, 1);
        step("reset_clears_ras", 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);

        // Five CALLs on a 4-deep RAS, four RETs, then RET on empty -> FAULT
        idle("to_1", 16'h0001, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step("call_chain", 0, 0, 0, 0, 1, 0, 16'(2 * i + 2), 16'(2 * i + 2), 1, 0,
                 (i == 4), (i >= 3) ? 3'd4 : 3'(i + 1));
            idle("call_bubble", 16'(2 * i + 3), 0, (i == 4), (i >= 3) ? 3'd4 : 3'(i + 1));
        end
        for (int i = 0; i < 4; i++) begin
            step("ret_chain", 0, 0, 0, 0, 0, 1, 16'h0000, 16'(9 - 2 * i), 1, 0, 1, 3'(3 - i));
            idle("ret_bubble", 16'(10 - 2 * i), 0, 1, 3'(3 - i));
        end
        step("ret_empty", 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0004, 1, 1, 1, 0);
        idle("fault_frozen", 16'h0004, 1, 1, 0);
        step("fault_ignores", 0, 0, 1, 1, 1, 0, 16'h0300, 16'h0004, 0, 1, 1, 0);
        step("fault_stall", 0, 1, 0, 0, 0, 1, 16'h0000, 16'h0004, 0, 1, 1, 0);
        step("fault_reset", 1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        idle("post_reset", 16'h0001, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
